ldpc_wb_frame_loader: RTL and testbench

- Wishbone slave bridge that sits directly upstream of the ldpcEncDec core inside the user project.
- Buffers an NN-bit codeword written as 32-bit words and hands it to the core over a valid/ready handshake.
- Captures the core's NN-bit result together with its syndrome sum and error flag.
- Exposes control, status and result registers to the management SoC and raises an interrupt on completion.

---
 rtl/ldpc_wb_pkg.sv | 31 +++
 rtl/ldpc_wb_regif.sv | 94 +++++++++
 rtl/ldpc_wb_frame_loader.sv | 215 +++++++++++++++++++++
 tb/tb_ldpc_wb_frame_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_wb_pkg.sv
// Shared constants for the LDPC Wishbone frame loader: register offsets, bit indices,
// FSM state encoding and the codeword word-count derivation.
package ldpc_wb_pkg;

    localparam int unsigned WordW = 32;

    localparam logic [7:0] OffCtrl    = 8'h00;
    localparam logic [7:0] OffStatus  = 8'h04;
    localparam logic [7:0] OffSum     = 8'h08;
    localparam logic [1:0] OffCwPage  = 2'b01;  // 0x40..0x7C
    localparam logic [1:0] OffResPage = 2'b10;  // 0x80..0xBC

    localparam int unsigned CtrlStart  = 0;
    localparam int unsigned CtrlClr    = 1;
    localparam int unsigned CtrlIrqEn  = 2;
    localparam int unsigned CtrlLimLsb = 16;

    localparam int unsigned StatBusy    = 0;
    localparam int unsigned StatDone    = 1;
    localparam int unsigned StatDecErr  = 2;
    localparam int unsigned StatWrViol  = 3;
    localparam int unsigned StatTimeout = 4;
    localparam int unsigned StatMmLsb   = 8;

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    function automatic int unsigned calc_nw(int unsigned nn);
        return (nn + WordW - 1) / WordW;
    endfunction

endpackage

// File: rtl/ldpc_wb_regif.sv
// Wishbone slave front end: window decode, single-cycle ack, registered read mux and
// write strobes for the CTRL register and the codeword buffer.
module ldpc_wb_regif
    import ldpc_wb_pkg::*;
#(
    parameter int unsigned NW       = 7,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [31:0]      ctrl_rd_i,
    input  logic [31:0]      status_rd_i,
    input  logic [31:0]      sum_rd_i,
    input  logic [NW*32-1:0] cw_rd_i,
    input  logic [NW*32-1:0] res_rd_i,
    output logic             ctrl_we_o,
    output logic             cw_we_o,
    output logic [3:0]       cw_idx_o,
    output logic [31:0]      wdata_o,
    output logic [31:0]      wmask_o
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        hit, acc;
    logic [7:0]  woff;
    logic [3:0]  widx;
    logic        cw_hit, res_hit;
    logic [31:0] rd;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];
    assign woff = {wbs_adr_i[7:2], 2'b00};
    assign widx = wbs_adr_i[5:2];
    assign hit  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    // Blocking on ack_q makes a held strobe produce exactly one ack per access.
    assign acc  = hit & ~ack_q;

    always_comb begin
        cw_hit  = 1'b0;
        res_hit = 1'b0;
        rd      = '0;
        for (int i = 0; i < int'(NW); i++) begin
            if (widx == 4'(i) && woff[7:6] == OffCwPage) begin
                cw_hit = 1'b1;
                rd     = cw_rd_i[i*32 +: 32];
            end
            if (widx == 4'(i) && woff[7:6] == OffResPage) begin
                res_hit = 1'b1;
                rd      = res_rd_i[i*32 +: 32];
            end
        end
        if (!cw_hit && !res_hit) begin
            case (woff)
                OffCtrl:   rd = ctrl_rd_i;
                OffStatus: rd = status_rd_i;
                OffSum:    rd = sum_rd_i;
                default:   rd = '0;
            endcase
        end
    end

    always_comb begin
        ack_d = acc;
        dat_d = (acc && !wbs_we_i) ? rd : dat_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign ctrl_we_o = acc & wbs_we_i & (woff == OffCtrl);
    assign cw_we_o   = acc & wbs_we_i & cw_hit;
    assign cw_idx_o  = widx;
    assign wdata_o   = wbs_dat_i;
    assign wmask_o   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

endmodule

// File: rtl/ldpc_wb_frame_loader.sv
// Wishbone-to-ldpcEncDec bridge: codeword/result buffers, control FSM and interrupt.
// Optional watchdog on SEND/WAIT enabled by defining LDPC_WB_TIMEOUT_EN.
module ldpc_wb_frame_loader
    import ldpc_wb_pkg::*;
#(
    parameter int unsigned NN       = 208,
    parameter int unsigned MM       = 168,
    parameter int unsigned SUM_LEN  = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               cw_valid_o,
    input  logic               cw_ready_i,
    output logic [NN-1:0]      cw_data_o,
    input  logic               res_valid_i,
    output logic               res_ready_o,
    input  logic [NN-1:0]      res_data_i,
    input  logic [SUM_LEN-1:0] res_sum_i,
    input  logic               res_err_i,
    output logic               irq_o
);

    localparam int unsigned NW   = calc_nw(NN);
    localparam int unsigned BufW = NW * 32;
    localparam int unsigned PadW = BufW - NN;
    localparam logic [BufW-1:0] ValidMask = {BufW{1'b1}} >> PadW;

    state_e            state_q, state_d;
    logic [BufW-1:0]   cw_q, cw_d, res_q, res_d;
    logic [31:0]       sum_q, sum_d;
    logic              done_q, done_d, dec_err_q, dec_err_d;
    logic              wr_viol_q, wr_viol_d, irq_en_q, irq_en_d;
    logic              ctrl_we, cw_we, start, clr, busy;
    logic [3:0]        cw_idx;
    logic [31:0]       wdata, wmask, ctrl_rd, status_rd;
`ifdef LDPC_WB_TIMEOUT_EN
    logic              timeout_q, timeout_d;
    logic [15:0]       wd_q, wd_d, lim_q, lim_d, limit;
`endif

    ldpc_wb_regif #(
        .NW       (NW),
        .BASE_ADR (BASE_ADR)
    ) u_regif (
        .clk_i       (wb_clk_i),
        .rst_ni      (wb_rst_n_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .ctrl_rd_i   (ctrl_rd),
        .status_rd_i (status_rd),
        .sum_rd_i    (sum_q),
        .cw_rd_i     (cw_q),
        .res_rd_i    (res_q),
        .ctrl_we_o   (ctrl_we),
        .cw_we_o     (cw_we),
        .cw_idx_o    (cw_idx),
        .wdata_o     (wdata),
        .wmask_o     (wmask)
    );

    assign busy  = (state_q == StSend) || (state_q == StWait);
    assign start = ctrl_we & wdata[CtrlStart] & wmask[CtrlStart];
    assign clr   = ctrl_we & wdata[CtrlClr] & wmask[CtrlClr];

    always_comb begin
        state_d   = state_q;
        cw_d      = cw_q;
        res_d     = res_q;
        sum_d     = sum_q;
        done_d    = done_q;
        dec_err_d = dec_err_q;
        wr_viol_d = wr_viol_q;
        irq_en_d  = irq_en_q;
`ifdef LDPC_WB_TIMEOUT_EN
        timeout_d = timeout_q;
        lim_d     = lim_q;
        wd_d      = busy ? wd_q + 16'd1 : 16'd0;
        if (ctrl_we) lim_d = (wdata[31:16] & wmask[31:16]) | (lim_q & ~wmask[31:16]);
`endif
        if (ctrl_we && wmask[CtrlIrqEn]) irq_en_d = wdata[CtrlIrqEn];

        // The core may be sampling cw_data_o, so the buffer is frozen while busy.
        if (cw_we) begin
            if (busy) begin
                wr_viol_d = 1'b1;
            end else begin
                for (int i = 0; i < int'(NW); i++) begin
                    if (cw_idx == 4'(i)) cw_d[i*32 +: 32] = (cw_q[i*32 +: 32] & ~wmask) | (wdata & wmask);
                end
            end
        end
        cw_d = cw_d & ValidMask;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d   = StSend;
                    done_d    = 1'b0;
                    dec_err_d = 1'b0;
                    wr_viol_d = 1'b0;
`ifdef LDPC_WB_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            StSend: if (cw_ready_i) state_d = StWait;
            StWait: begin
                if (res_valid_i) begin
                    state_d   = StDone;
                    res_d     = BufW'(res_data_i);
                    sum_d     = 32'(res_sum_i);
                    dec_err_d = res_err_i;
                    done_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef LDPC_WB_TIMEOUT_EN
        if (busy && (wd_q + 16'd1 == limit)) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
            done_d    = 1'b1;
        end
`endif

        // CLR outranks START and any result landing in the same cycle.
        if (clr) begin
            state_d   = StIdle;
            res_d     = '0;
            sum_d     = '0;
            done_d    = 1'b0;
            dec_err_d = 1'b0;
            wr_viol_d = 1'b0;
`ifdef LDPC_WB_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= StIdle;
            cw_q      <= '0;
            res_q     <= '0;
            sum_q     <= '0;
            done_q    <= 1'b0;
            dec_err_q <= 1'b0;
            wr_viol_q <= 1'b0;
            irq_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cw_q      <= cw_d;
            res_q     <= res_d;
            sum_q     <= sum_d;
            done_q    <= done_d;
            dec_err_q <= dec_err_d;
            wr_viol_q <= wr_viol_d;
            irq_en_q  <= irq_en_d;
        end
    end

`ifdef LDPC_WB_TIMEOUT_EN
    assign limit = (lim_q != 16'd0) ? lim_q : 16'hFFFF;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            timeout_q <= 1'b0;
            wd_q      <= '0;
            lim_q     <= '0;
        end else begin
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
            lim_q     <= lim_d;
        end
    end
`endif

    always_comb begin
        ctrl_rd                  = '0;
        ctrl_rd[CtrlIrqEn]       = irq_en_q;
        status_rd                = '0;
        status_rd[StatBusy]      = busy;
        status_rd[StatDone]      = done_q;
        status_rd[StatDecErr]    = dec_err_q;
        status_rd[StatWrViol]    = wr_viol_q;
        status_rd[StatMmLsb +: 16] = 16'(MM);
`ifdef LDPC_WB_TIMEOUT_EN
        ctrl_rd[CtrlLimLsb +: 16] = lim_q;
        status_rd[StatTimeout]    = timeout_q;
`endif
    end

    assign cw_valid_o  = (state_q == StSend);
    assign res_ready_o = (state_q == StWait);
    assign cw_data_o   = cw_q[NN-1:0];
    assign irq_o       = done_q & irq_en_q;

endmodule

// File: tb/tb_ldpc_wb_frame_loader.sv
// Directed self-checking bench for ldpc_wb_frame_loader with a word-array model of the buffers.
`timescale 1ns/1ps
module tb_ldpc_wb_frame_loader;

    localparam int unsigned NN      = 208;
    localparam int unsigned MM      = 168;
    localparam int unsigned SUM_LEN = 32;
    localparam int unsigned NW      = 7;
    localparam logic [31:0] BASE    = 32'h3000_0000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cyc, stb, we;
    logic [3:0]         sel;
    logic [31:0]        adr, dat;
    logic               wbs_ack_o;
    logic [31:0]        wbs_dat_o;
    logic               cw_valid_o, cw_ready_i;
    logic [NN-1:0]      cw_data_o;
    logic               res_valid_i, res_ready_o;
    logic [NN-1:0]      res_data_i;
    logic [SUM_LEN-1:0] res_sum_i;
    logic               res_err_i;
    logic               irq_o;

    always #5 clk = ~clk;

    ldpc_wb_frame_loader dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .cw_valid_o  (cw_valid_o),
        .cw_ready_i  (cw_ready_i),
        .cw_data_o   (cw_data_o),
        .res_valid_i (res_valid_i),
        .res_ready_o (res_ready_o),
        .res_data_i  (res_data_i),
        .res_sum_i   (res_sum_i),
        .res_err_i   (res_err_i),
        .irq_o       (irq_o)
    );

    int          total = 0;
    int          bad = 0;
    int          hs_count = 0;
    logic [31:0] cw_model [NW];
    logic [31:0] rd;
    logic [NN-1:0] sent;
    logic        ack_prev = 1'b0;
    logic        got;

    function automatic logic [31:0] word_mask(input int i);
        int nbits;
        nbits = int'(NN) - i * 32;
        if (nbits >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << nbits) - 32'd1;
    endfunction

    function automatic logic [NN-1:0] model_cw();
        logic [NW*32-1:0] v;
        for (int i = 0; i < int'(NW); i++) v[i*32 +: 32] = cw_model[i];
        return v[NN-1:0];
    endfunction

    task automatic model_write(input int i, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = cw_model[i];
        for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        cw_model[i] = w & word_mask(i);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] q);
        logic ok;
        ok  = 1'b0;
        q   = '0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        for (int n = 0; n < 16 && !ok; n++) begin
            @(posedge clk); #1;
            ok = wbs_ack_o;
        end
        q   = wbs_dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wb_ack_timeout adr=%h: got no ack expected ack", a);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        wb_access(a, 1'b1, d, s, q);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
        wb_access(a, 1'b0, 32'h0, 4'hF, q);
    endtask

    // Continuous checks: presented codeword matches the model, one-cycle acks, exclusive phases.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cw_valid_o) begin
                total++;
                if (cw_data_o !== model_cw()) begin
                    bad++;
                    $display("FAIL cw_data: got %h expected %h", cw_data_o, model_cw());
                end
                if (cw_ready_i) hs_count++;
            end
            if (cw_valid_o && res_ready_o) begin
                total++;
                bad++;
                $display("FAIL phase_overlap: got valid&ready=1 expected 0");
            end
            if (wbs_ack_o) begin
                total++;
                if (ack_prev) begin
                    bad++;
                    $display("FAIL ack_width: got 2-cycle ack expected 1");
                end
            end
            ack_prev = wbs_ack_o;
        end else begin
            ack_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
        cw_ready_i = 1'b0; res_valid_i = 1'b0; res_data_i = '0; res_sum_i = '0; res_err_i = 1'b0;
        for (int i = 0; i < int'(NW); i++) cw_model[i] = '0;
        #12;
        check("rst_ctl_outs", 32'({cw_valid_o, res_ready_o, irq_o, wbs_ack_o}), 32'h0);
        check("rst_cw_data", 32'(|cw_data_o), 32'h0);
        check("rst_dat_o", wbs_dat_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(BASE + 32'h04, rd);
        check("status_reset", rd, 32'h0000_A800);

        // Load and read back the codeword buffer
        for (int i = 0; i < int'(NW); i++) begin
            wb_write(BASE + 32'h40 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF);
            model_write(i, 32'hA5A5_0000 + 32'(i), 4'hF);
        end
        for (int i = 0; i < int'(NW); i++) begin
            wb_read(BASE + 32'h40 + 32'(4 * i), rd);
            check("cw_readback", rd, cw_model[i]);
        end
        check("cw_top_word_lit", rd, 32'h0000_0006);

        // Byte selects
        wb_write(BASE + 32'h44, 32'h0, 4'hF);
        model_write(1, 32'h0, 4'hF);
        wb_write(BASE + 32'h44, 32'hDEAD_BEEF, 4'b0101);
        model_write(1, 32'hDEAD_BEEF, 4'b0101);
        wb_read(BASE + 32'h44, rd);
        check("bytesel_lit", rd, 32'h00AD_00EF);
        check("bytesel_model", rd, cw_model[1]);

        // Unmapped offsets ack and read 0; out-of-window accesses get no ack
        wb_write(BASE + 32'h0C, 32'h1234_5678, 4'hF);
        wb_read(BASE + 32'h0C, rd);
        check("unmapped_0c", rd, 32'h0);
        wb_read(BASE + 32'h5C, rd);
        check("unmapped_cw7", rd, 32'h0);
        wb_read(BASE + 32'hC0, rd);
        check("unmapped_c0", rd, 32'h0);
        got = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            got = got | wbs_ack_o;
        end
        cyc = 1'b0; stb = 1'b0;
        check("miss_no_ack", 32'(got), 32'h0);

        // Normal run with a 5-cycle ready stall
        wb_write(BASE, 32'h4, 4'hF);
        wb_write(BASE, 32'h5, 4'hF);
        check("valid_on_start", 32'(cw_valid_o), 32'h1);
        wb_read(BASE + 32'h04, rd);
        check("status_busy", rd, 32'h0000_A801);
        repeat (3) begin @(posedge clk); #1; end
        check("valid_in_stall", 32'(cw_valid_o), 32'h1);
        sent = cw_data_o;
        cw_ready_i = 1'b1;
        @(posedge clk); #1;
        cw_ready_i = 1'b0;
        check("valid_drop", 32'(cw_valid_o), 32'h0);
        check("res_ready_up", 32'(res_ready_o), 32'h1);

        // Busy protection while waiting for the result
        wb_write(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
        wb_write(BASE, 32'h5, 4'hF);
        wb_read(BASE + 32'h04, rd);
        check("status_wr_viol", rd, 32'h0000_A809);
        @(posedge clk); #1;
        res_data_i = ~sent; res_sum_i = 32'd3; res_err_i = 1'b0; res_valid_i = 1'b1;
        @(posedge clk); #1;
        res_valid_i = 1'b0;
        check("res_ready_drop", 32'(res_ready_o), 32'h0);
        wb_read(BASE + 32'h04, rd);
        check("status_done", rd, 32'h0000_A80A);
        wb_read(BASE + 32'h08, rd);
        check("sum", rd, 32'd3);
        for (int i = 0; i < int'(NW); i++) begin
            wb_read(BASE + 32'h80 + 32'(4 * i), rd);
            check("res_word", rd, ~cw_model[i] & word_mask(i));
            if (i == 0) check("res_word0_lit", rd, 32'h5A5A_FFFF);
        end
        wb_read(BASE + 32'h40, rd);
        check("cw_kept_busy", rd, cw_model[0]);
        check("irq_done", 32'(irq_o), 32'h1);
        repeat (4) begin @(posedge clk); #1; end
        check("one_handshake", 32'(hs_count), 32'd1);

        // CLR in WAIT with a result arriving in the same cycle
        wb_write(BASE, 32'h5, 4'hF);
        cw_ready_i = 1'b1;
        @(posedge clk); #1;
        cw_ready_i = 1'b0;
        check("clr_in_wait", 32'(res_ready_o), 32'h1);
        res_data_i = '1; res_sum_i = 32'd7; res_err_i = 1'b1; res_valid_i = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat = 32'h2; sel = 4'hF;
        @(posedge clk); #1;
        check("clr_ack", 32'(wbs_ack_o), 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; res_valid_i = 1'b0;
        check("clr_outs", 32'({cw_valid_o, res_ready_o, irq_o}), 32'h0);
        wb_read(BASE + 32'h04, rd);
        check("clr_status", rd, 32'h0000_A800);
        wb_read(BASE + 32'h08, rd);
        check("clr_sum", rd, 32'h0);
        for (int i = 0; i < int'(NW); i++) begin
            wb_read(BASE + 32'h80 + 32'(4 * i), rd);
            check("clr_res_word", rd, 32'h0);
        end
        wb_read(BASE + 32'h44, rd);
        check("clr_cw_kept", rd, cw_model[1]);

        // Asynchronous reset mid-SEND with a read ack pending
        wb_write(BASE, 32'h1, 4'hF);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h04;
        @(posedge clk); #2;
        check("pre_rst_valid", 32'(cw_valid_o), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_ctl_outs", 32'({cw_valid_o, res_ready_o, irq_o, wbs_ack_o}), 32'h0);
        check("arst_cw_data", 32'(|cw_data_o), 32'h0);
        check("arst_dat_o", wbs_dat_o, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < int'(NW); i++) cw_model[i] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read(BASE + 32'h40, rd);
        check("arst_cw_buf", rd, 32'h0);

`ifdef LDPC_WB_TIMEOUT_EN
        wb_write(BASE, 32'h0010_0001, 4'hF);
        repeat (15) begin @(posedge clk); #1; end
        check("wd_still_send", 32'(cw_valid_o), 32'h1);
        @(posedge clk); #1;
        check("wd_expired", 32'(cw_valid_o), 32'h0);
        wb_read(BASE + 32'h04, rd);
        check("status_timeout", rd, 32'h0000_A812);
        wb_read(BASE, rd);
        check("ctrl_limit", rd, 32'h0010_0000);
`else
        wb_write(BASE, 32'hFFFF_0004, 4'hF);
        wb_read(BASE, rd);
        check("ctrl_no_limit", rd, 32'h0000_0004);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
